// File: rtl/core_run_sequencer.sv
// Run controller for the pipelined core: drives the core reset for NUM_RUNS runs,
// times each run, ends it on halt or on the cycle limit, and keeps per-sequence statistics.
module core_run_sequencer #(
   parameter int RST_CYCLES = 2,
   parameter int RUN_CYCLES = 50,
   parameter int NUM_RUNS   = 2,
   parameter int CNT_W      = 16,
   localparam int RUN_W     = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt_i,
   output logic             core_rst_o,
   output logic             running_o,
   output logic [RUN_W-1:0] run_idx_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] last_cycles_o,
   output logic [RUN_W:0]   halt_cnt_o,
   output logic [RUN_W:0]   timeout_cnt_o,
   output logic             done_o
);

   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic             core_rst_q, core_rst_d;
   logic             running_q, running_d;
   logic [RUN_W-1:0] run_idx_q, run_idx_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] last_cycles_q, last_cycles_d;
   logic [RUN_W:0]   halt_cnt_q, halt_cnt_d;
   logic [RUN_W:0]   timeout_cnt_q, timeout_cnt_d;
   logic             done_q, done_d;

   logic             run_end_s;
   logic             last_run_s;

   // A halt in the same cycle as the limit wins, so the limit only matters without halt_i.
   assign run_end_s  = halt_i || (cycle_cnt_q == CNT_W'(RUN_CYCLES - 1));
   assign last_run_s = (run_idx_q == RUN_W'(NUM_RUNS - 1));

   // State and statistics register; reset holds the core in reset and clears everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rst_cnt_q     <= '0;
         core_rst_q    <= 1'b1;
         running_q     <= 1'b0;
         run_idx_q     <= '0;
         cycle_cnt_q   <= '0;
         last_cycles_q <= '0;
         halt_cnt_q    <= '0;
         timeout_cnt_q <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         core_rst_q    <= core_rst_d;
         running_q     <= running_d;
         run_idx_q     <= run_idx_d;
         cycle_cnt_q   <= cycle_cnt_d;
         last_cycles_q <= last_cycles_d;
         halt_cnt_q    <= halt_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         done_q        <= done_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      core_rst_d    = core_rst_q;
      running_d     = running_q;
      run_idx_d     = run_idx_q;
      cycle_cnt_d   = cycle_cnt_q;
      last_cycles_d = last_cycles_q;
      halt_cnt_d    = halt_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      done_d        = done_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d       = ST_RESET;
               rst_cnt_d     = '0;
               core_rst_d    = 1'b1;
               running_d     = 1'b0;
               run_idx_d     = '0;
               cycle_cnt_d   = '0;
               last_cycles_d = '0;
               halt_cnt_d    = '0;
               timeout_cnt_d = '0;
               done_d        = 1'b0;
            end else begin
               state_d = state_q;
            end
         end

         ST_RESET: begin
            if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
               state_d     = ST_RUN;
               cycle_cnt_d = '0;
               core_rst_d  = 1'b0;
               running_d   = 1'b1;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end

         ST_RUN: begin
            if (run_end_s) begin
               last_cycles_d = cycle_cnt_q + CNT_W'(1);
               if (halt_i) begin
                  halt_cnt_d = halt_cnt_q + (RUN_W+1)'(1);
               end else begin
                  timeout_cnt_d = timeout_cnt_q + (RUN_W+1)'(1);
               end
               core_rst_d = 1'b1;
               running_d  = 1'b0;
               if (last_run_s) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = ST_RESET;
                  rst_cnt_d = '0;
                  run_idx_d = run_idx_q + RUN_W'(1);
               end
            end else begin
               cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d    = ST_IDLE;
            core_rst_d = 1'b1;
            running_d  = 1'b0;
            done_d     = 1'b0;
         end
      endcase
   end

   assign core_rst_o    = core_rst_q;
   assign running_o     = running_q;
   assign run_idx_o     = run_idx_q;
   assign cycle_cnt_o   = cycle_cnt_q;
   assign last_cycles_o = last_cycles_q;
   assign halt_cnt_o    = halt_cnt_q;
   assign timeout_cnt_o = timeout_cnt_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Directed bench for core_run_sequencer at default parameters; outputs sampled on the falling edge.
module tb_core_run_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        halt_i;
   logic        core_rst_o;
   logic        running_o;
   logic [0:0]  run_idx_o;
   logic [15:0] cycle_cnt_o;
   logic [15:0] last_cycles_o;
   logic [1:0]  halt_cnt_o;
   logic [1:0]  timeout_cnt_o;
   logic        done_o;

   int errors;
   int checks;

   core_run_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .halt_i        (halt_i),
      .core_rst_o    (core_rst_o),
      .running_o     (running_o),
      .run_idx_o     (run_idx_o),
      .cycle_cnt_o   (cycle_cnt_o),
      .last_cycles_o (last_cycles_o),
      .halt_cnt_o    (halt_cnt_o),
      .timeout_cnt_o (timeout_cnt_o),
      .done_o        (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns at the falling edge right after the edge that sampled start.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic skip(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      halt_i = 1'b0;
      skip(2);
      checks++;
      if ({core_rst_o, running_o, run_idx_o, cycle_cnt_o, last_cycles_o, halt_cnt_o, timeout_cnt_o, done_o}
          !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 2'd0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: core_rst=%b running=%b idx=%0d cnt=%0d last=%0d halt=%0d to=%0d done=%b, need 1 0 0 0 0 0 0 0",
                  core_rst_o, running_o, run_idx_o, cycle_cnt_o, last_cycles_o, halt_cnt_o, timeout_cnt_o, done_o);
      end
      rst = 1'b0;
      skip(3);
      checks++;
      if ({core_rst_o, running_o, done_o} !== 3'b100) begin
         errors++;
         $display("FAIL idle_after_reset: core_rst/running/done=%b need 100", {core_rst_o, running_o, done_o});
      end
   endtask

   task automatic test_timeout();
      pulse_start();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({core_rst_o, running_o} !== 2'b10 || run_idx_o !== 1'(r)) begin
               errors++;
               $display("FAIL to_reset_phase r%0d c%0d: core_rst/running=%b idx=%0d need 10 idx=%0d",
                        r, i, {core_rst_o, running_o}, run_idx_o, r);
            end
            @(negedge clk);
         end
         for (int i = 0; i < 50; i++) begin
            checks++;
            if ({core_rst_o, running_o} !== 2'b01 || cycle_cnt_o !== 16'(i)) begin
               errors++;
               $display("FAIL to_run_phase r%0d c%0d: core_rst/running=%b cnt=%0d need 01 cnt=%0d",
                        r, i, {core_rst_o, running_o}, cycle_cnt_o, i);
            end
            @(negedge clk);
         end
         if (r == 0) begin
            checks++;
            if (timeout_cnt_o !== 2'd1 || last_cycles_o !== 16'd50 || halt_cnt_o !== 2'd0) begin
               errors++;
               $display("FAIL to_first_end: to=%0d last=%0d halt=%0d need 1 50 0",
                        timeout_cnt_o, last_cycles_o, halt_cnt_o);
            end
         end
      end
      checks++;
      if ({done_o, core_rst_o, running_o} !== 3'b110 || timeout_cnt_o !== 2'd2 ||
          halt_cnt_o !== 2'd0 || last_cycles_o !== 16'd50) begin
         errors++;
         $display("FAIL to_done: done/core_rst/running=%b to=%0d halt=%0d last=%0d need 110 2 0 50",
                  {done_o, core_rst_o, running_o}, timeout_cnt_o, halt_cnt_o, last_cycles_o);
      end
      skip(3);
      checks++;
      if (done_o !== 1'b1 || timeout_cnt_o !== 2'd2 || cycle_cnt_o !== 16'd49) begin
         errors++;
         $display("FAIL done_hold: done=%b to=%0d cnt=%0d need 1 2 49", done_o, timeout_cnt_o, cycle_cnt_o);
      end
   endtask

   task automatic test_halt();
      pulse_start();
      checks++;
      if ({done_o, core_rst_o} !== 2'b01 || timeout_cnt_o !== 2'd0 || run_idx_o !== 1'b0 ||
          last_cycles_o !== 16'd0 || cycle_cnt_o !== 16'd0) begin
         errors++;
         $display("FAIL restart_from_done: done/core_rst=%b to=%0d idx=%0d last=%0d cnt=%0d need 01 0 0 0 0",
                  {done_o, core_rst_o}, timeout_cnt_o, run_idx_o, last_cycles_o, cycle_cnt_o);
      end
      skip(12);
      checks++;
      if (cycle_cnt_o !== 16'd10 || running_o !== 1'b1) begin
         errors++;
         $display("FAIL halt_setup: cnt=%0d running=%b need 10 1", cycle_cnt_o, running_o);
      end
      halt_i = 1'b1;
      @(negedge clk);
      halt_i = 1'b0;
      checks++;
      if (last_cycles_o !== 16'd11 || halt_cnt_o !== 2'd1 || run_idx_o !== 1'b1 ||
          timeout_cnt_o !== 2'd0 || {core_rst_o, running_o} !== 2'b10) begin
         errors++;
         $display("FAIL halt_at_10: last=%0d halt=%0d idx=%0d to=%0d core_rst/running=%b need 11 1 1 0 10",
                  last_cycles_o, halt_cnt_o, run_idx_o, timeout_cnt_o, {core_rst_o, running_o});
      end
      @(negedge clk);
      checks++;
      if (core_rst_o !== 1'b1) begin
         errors++;
         $display("FAIL halt_rst_second: core_rst=%b need 1", core_rst_o);
      end
      @(negedge clk);
      checks++;
      if ({core_rst_o, running_o} !== 2'b01 || cycle_cnt_o !== 16'd0) begin
         errors++;
         $display("FAIL halt_rerun: core_rst/running=%b cnt=%0d need 01 0", {core_rst_o, running_o}, cycle_cnt_o);
      end
      skip(49);
      halt_i = 1'b1;
      @(negedge clk);
      halt_i = 1'b0;
      checks++;
      if (halt_cnt_o !== 2'd2 || timeout_cnt_o !== 2'd0 || last_cycles_o !== 16'd50 || done_o !== 1'b1) begin
         errors++;
         $display("FAIL halt_at_limit: halt=%0d to=%0d last=%0d done=%b need 2 0 50 1",
                  halt_cnt_o, timeout_cnt_o, last_cycles_o, done_o);
      end
   endtask

   task automatic test_start_ignored();
      pulse_start();
      skip(7);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (cycle_cnt_o !== 16'd6 || running_o !== 1'b1 || run_idx_o !== 1'b0) begin
         errors++;
         $display("FAIL start_in_run: cnt=%0d running=%b idx=%0d need 6 1 0", cycle_cnt_o, running_o, run_idx_o);
      end
      skip(1);
      halt_i = 1'b1;
      @(negedge clk);
      halt_i = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (running_o !== 1'b1 || run_idx_o !== 1'b1 || halt_cnt_o !== 2'd1 || last_cycles_o !== 16'd8) begin
         errors++;
         $display("FAIL start_in_reset: running=%b idx=%0d halt=%0d last=%0d need 1 1 1 8",
                  running_o, run_idx_o, halt_cnt_o, last_cycles_o);
      end
      skip(3);
      halt_i = 1'b1;
      @(negedge clk);
      halt_i = 1'b0;
      checks++;
      if (done_o !== 1'b1 || halt_cnt_o !== 2'd2 || last_cycles_o !== 16'd4) begin
         errors++;
         $display("FAIL start_seq_end: done=%b halt=%0d last=%0d need 1 2 4", done_o, halt_cnt_o, last_cycles_o);
      end
   endtask

   task automatic test_async_reset();
      pulse_start();
      skip(22);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({core_rst_o, running_o, run_idx_o, cycle_cnt_o, last_cycles_o, halt_cnt_o, timeout_cnt_o, done_o}
          !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 2'd0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: core_rst=%b running=%b idx=%0d cnt=%0d last=%0d halt=%0d to=%0d done=%b, need 1 0 0 0 0 0 0 0",
                  core_rst_o, running_o, run_idx_o, cycle_cnt_o, last_cycles_o, halt_cnt_o, timeout_cnt_o, done_o);
      end
      skip(2);
      rst = 1'b0;
      skip(4);
      checks++;
      if ({core_rst_o, running_o, done_o} !== 3'b100 || cycle_cnt_o !== 16'd0) begin
         errors++;
         $display("FAIL idle_wait_start: core_rst/running/done=%b cnt=%0d need 100 0",
                  {core_rst_o, running_o, done_o}, cycle_cnt_o);
      end
   endtask

   task automatic test_halt_held();
      halt_i = 1'b1;
      skip(2);
      pulse_start();
      @(negedge clk);
      checks++;
      if (halt_cnt_o !== 2'd0 || core_rst_o !== 1'b1 || last_cycles_o !== 16'd0) begin
         errors++;
         $display("FAIL held_in_reset: halt=%0d core_rst=%b last=%0d need 0 1 0", halt_cnt_o, core_rst_o, last_cycles_o);
      end
      @(negedge clk);
      checks++;
      if (running_o !== 1'b1 || cycle_cnt_o !== 16'd0 || halt_cnt_o !== 2'd0) begin
         errors++;
         $display("FAIL held_first_run: running=%b cnt=%0d halt=%0d need 1 0 0", running_o, cycle_cnt_o, halt_cnt_o);
      end
      @(negedge clk);
      checks++;
      if (last_cycles_o !== 16'd1 || halt_cnt_o !== 2'd1 || run_idx_o !== 1'b1 || core_rst_o !== 1'b1) begin
         errors++;
         $display("FAIL held_run_end: last=%0d halt=%0d idx=%0d core_rst=%b need 1 1 1 1",
                  last_cycles_o, halt_cnt_o, run_idx_o, core_rst_o);
      end
      skip(3);
      halt_i = 1'b0;
      checks++;
      if (done_o !== 1'b1 || halt_cnt_o !== 2'd2 || timeout_cnt_o !== 2'd0 || last_cycles_o !== 16'd1) begin
         errors++;
         $display("FAIL held_done: done=%b halt=%0d to=%0d last=%0d need 1 2 0 1",
                  done_o, halt_cnt_o, timeout_cnt_o, last_cycles_o);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_timeout();
      test_halt();
      test_start_ignored();
      test_async_reset();
      test_halt_held();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
